sm83_irq_ctrl: RTL and testbench

- Interrupt controller and dispatch sequencer for the sm83 core.
- Owns the IF (0xFF0F) and IE (0xFFFF) registers and the IME flag.
- Resolves priority among peripheral requests and runs the 5 M-cycle dispatch sequence.
- The sequence drives the core's PC push and vector jump. It sits beside the decoder, which supplies EI/DI/RETI strobes, instruction-boundary timing and HALT status.

---
 rtl/sm83_irq_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_sm83_irq_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sm83_irq_ctrl.sv
// Interrupt controller for the sm83 core: owns IF/IE/IME, resolves priority and sequences dispatch.
// Latency: irq_take is combinational; the dispatch sequence spans 5 further M-cycles back to IDLE.
// Backpressure: none; the core honours irq_take by suppressing its fetch, all state advances on m_tick.
//
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   m_tick                      M-cycle strobe qualifying IME/FSM/vector updates
//   irq_req[NUM_IRQ-1:0]        request pulses, each sets its IF bit in any clk cycle
//   reg_wr_en/reg_sel/reg_wdata register write port (sel 0 = IF, 1 = IE)
//   reg_rdata                   IF reads {3'b111, IF}, IE reads all 8 bits
//   instr_boundary, ctl_ei, ctl_di, ctl_reti, halted   decoder timing and strobes
//   wake, irq_take, ime         pending indication, dispatch accept, master enable
//   disp_active, disp_push_hi, disp_push_lo, disp_jump, vector   dispatch sequence to the core
module sm83_irq_ctrl #(
    parameter int          NUM_IRQ    = 5,
    parameter logic [15:0] VEC_BASE   = 16'h0040,
    parameter int          VEC_STRIDE = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               m_tick,
    input  logic [NUM_IRQ-1:0] irq_req,
    input  logic               reg_wr_en,
    input  logic               reg_sel,
    input  logic [7:0]         reg_wdata,
    output logic [7:0]         reg_rdata,
    input  logic               instr_boundary,
    input  logic               ctl_ei,
    input  logic               ctl_di,
    input  logic               ctl_reti,
    input  logic               halted,
    output logic               wake,
    output logic               irq_take,
    output logic               ime,
    output logic               disp_active,
    output logic               disp_push_hi,
    output logic               disp_push_lo,
    output logic               disp_jump,
    output logic [15:0]        vector
);

    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT0   = 3'd1,
        WAIT1   = 3'd2,
        PUSH_HI = 3'd3,
        PUSH_LO = 3'd4,
        JUMP    = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_IRQ-1:0] if_q, if_d;
    logic [7:0]         ie_q;
    logic               ime_q;
    logic               ei_delay_q;
    logic [15:0]        vector_q;

    logic [NUM_IRQ-1:0] pend;
    logic [NUM_IRQ-1:0] pend_lsb;
    logic [IDX_W-1:0]   pend_idx;
    logic               resolve;
    logic               idle;

    // HALT exit is the core's job; wake already carries the condition it needs.
    logic unused_halted;
    assign unused_halted = halted;

    // Position of the lowest set bit (highest priority source).
    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_IRQ-1:0] v);
        lowest_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = IDX_W'(i);
        end
    endfunction

    // Only the low NUM_IRQ bits of IE take part; upper IE bits are storage only.
    assign pend     = ie_q[NUM_IRQ-1:0] & if_q;
    assign pend_lsb = pend & (~pend + 1'b1);
    assign pend_idx = lowest_idx(pend);
    assign idle     = (state_q == IDLE);
    assign resolve  = m_tick && (state_q == PUSH_HI);

    assign wake     = |pend;
    assign irq_take = m_tick && instr_boundary && ime_q && wake && idle;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (m_tick) begin
            case (state_q)
                IDLE:    if (irq_take) state_d = WAIT0;
                WAIT0:   state_d = WAIT1;
                WAIT1:   state_d = PUSH_HI;
                PUSH_HI: state_d = PUSH_LO;
                PUSH_LO: state_d = JUMP;
                JUMP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        disp_active  = (state_q != IDLE);
        disp_push_hi = (state_q == PUSH_HI);
        disp_push_lo = (state_q == PUSH_LO);
        disp_jump    = (state_q == JUMP);
    end

    // ------------------------------------------------------------------
    // IF: dispatch clear, then register write, then new requests, so a
    // request arriving alongside a clear or write is never lost.
    // ------------------------------------------------------------------
    always_comb begin
        if_d = if_q;
        if (resolve) if_d = if_d & ~pend_lsb;
        if (reg_wr_en && !reg_sel) if_d = reg_wdata[NUM_IRQ-1:0];
        if_d = if_d | irq_req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_q <= '0;
            ie_q <= '0;
        end else begin
            if_q <= if_d;
            if (reg_wr_en && reg_sel) ie_q <= reg_wdata;
        end
    end

    // ------------------------------------------------------------------
    // IME. Later assignments take precedence: delayed EI promotion, RETI,
    // EI arm, DI, then dispatch entry. The promotion only looks at the
    // registered ei_delay, so an EI at this very boundary waits for the next
    // one and irq_take here still sees the old ime.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ime_q      <= 1'b0;
            ei_delay_q <= 1'b0;
        end else if (m_tick) begin
            if (idle) begin
                if (instr_boundary && ei_delay_q) begin
                    ime_q      <= 1'b1;
                    ei_delay_q <= 1'b0;
                end
                if (ctl_reti) ime_q <= 1'b1;
                if (ctl_ei)   ei_delay_q <= 1'b1;
                if (ctl_di) begin
                    ime_q      <= 1'b0;
                    ei_delay_q <= 1'b0;
                end
            end
            if (irq_take) begin
                ime_q      <= 1'b0;
                ei_delay_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Vector: resolved on leaving PUSH_HI using the enables/flags of that
    // cycle; if software cleared them during the push, the dispatch is
    // cancelled and jumps to 0x0000.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            vector_q <= '0;
        end else if (resolve) begin
            if (|pend) vector_q <= VEC_BASE + 16'(VEC_STRIDE) * 16'(pend_idx);
            else       vector_q <= 16'h0000;
        end
    end

    always_comb begin
        reg_rdata = 8'hFF;
        reg_rdata[NUM_IRQ-1:0] = if_q;
        if (reg_sel) reg_rdata = ie_q;
    end

    assign ime    = ime_q;
    assign vector = vector_q;

endmodule

// File: tb/tb_sm83_irq_ctrl.sv
// Self-checking bench for sm83_irq_ctrl.
// Latency: each M-cycle is two clk cycles with m_tick on the first.
// Backpressure: none; dispatch vectors are scoreboarded when the DUT enters JUMP.
module tb_sm83_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m_tick = 1'b0;
    logic [4:0]  irq_req = '0;
    logic        reg_wr_en = 1'b0;
    logic        reg_sel = 1'b0;
    logic [7:0]  reg_wdata = '0;
    logic [7:0]  reg_rdata;
    logic        instr_boundary = 1'b0;
    logic        ctl_ei = 1'b0;
    logic        ctl_di = 1'b0;
    logic        ctl_reti = 1'b0;
    logic        halted = 1'b0;
    logic        wake;
    logic        irq_take;
    logic        ime;
    logic        disp_active;
    logic        disp_push_hi;
    logic        disp_push_lo;
    logic        disp_jump;
    logic [15:0] vector;

    sm83_irq_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .m_tick         (m_tick),
        .irq_req        (irq_req),
        .reg_wr_en      (reg_wr_en),
        .reg_sel        (reg_sel),
        .reg_wdata      (reg_wdata),
        .reg_rdata      (reg_rdata),
        .instr_boundary (instr_boundary),
        .ctl_ei         (ctl_ei),
        .ctl_di         (ctl_di),
        .ctl_reti       (ctl_reti),
        .halted         (halted),
        .wake           (wake),
        .irq_take       (irq_take),
        .ime            (ime),
        .disp_active    (disp_active),
        .disp_push_hi   (disp_push_hi),
        .disp_push_lo   (disp_push_lo),
        .disp_jump      (disp_jump),
        .vector         (vector)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_vec[$];
    logic        t;
    logic [7:0]  rd;
    logic        jump_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: on entry to JUMP, pop the expected vector and compare.
    always @(negedge clk) begin
        if (rst) begin
            jump_prev = 1'b0;
        end else begin
            if (disp_jump && !jump_prev) begin
                if (exp_vec.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_dispatch: vector 0x%0h with nothing queued", vector);
                end else begin
                    chk("jump_vector", {16'h0, vector}, {16'h0, exp_vec.pop_front()});
                end
            end
            jump_prev = disp_jump;
        end
    end

    // All tasks start and end at posedge+1.
    task automatic mcycle(input logic b, input logic ei, input logic di, input logic reti,
                          output logic take);
        m_tick = 1'b1; instr_boundary = b; ctl_ei = ei; ctl_di = di; ctl_reti = reti;
        @(negedge clk);
        take = irq_take;
        @(posedge clk); #1;
        m_tick = 1'b0; instr_boundary = 1'b0; ctl_ei = 1'b0; ctl_di = 1'b0; ctl_reti = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic sel, input logic [7:0] d);
        reg_wr_en = 1'b1; reg_sel = sel; reg_wdata = d;
        @(posedge clk); #1;
        reg_wr_en = 1'b0;
    endtask

    task automatic req(input logic [4:0] r);
        irq_req = r;
        @(posedge clk); #1;
        irq_req = '0;
    endtask

    task automatic rdreg(input logic sel, output logic [7:0] d);
        reg_sel = sel;
        @(negedge clk);
        d = reg_rdata;
        @(posedge clk); #1;
    endtask

    // Remaining five M-cycles after the take tick.
    task automatic disp_tail(input logic [15:0] v, input logic [7:0] if_after);
        logic tk;
        logic [7:0] r;
        mcycle(0, 0, 0, 0, tk);
        mcycle(0, 0, 0, 0, tk);
        chk("push_hi_tick3", {31'h0, disp_push_hi}, 1);
        mcycle(0, 0, 0, 0, tk);
        chk("push_lo_tick4", {31'h0, disp_push_lo}, 1);
        chk("vector_push_lo", {16'h0, vector}, {16'h0, v});
        rdreg(0, r);
        chk("if_after_resolve", {24'h0, r}, {24'h0, if_after});
        mcycle(0, 0, 0, 0, tk);
        chk("jump_state", {31'h0, disp_jump}, 1);
        mcycle(0, 0, 0, 0, tk);
        chk("idle_after_5", {31'h0, disp_active}, 0);
        chk("ime_after_disp", {31'h0, ime}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        rdreg(0, rd); chk("rst_if", {24'h0, rd}, 32'hE0);
        rdreg(1, rd); chk("rst_ie", {24'h0, rd}, 32'h00);
        chk("rst_ime", {31'h0, ime}, 0);
        chk("rst_active", {31'h0, disp_active}, 0);
        chk("rst_vector", {16'h0, vector}, 0);
        chk("rst_wake", {31'h0, wake}, 0);

        // Basic VBlank dispatch
        wr(1, 8'h01);
        mcycle(0, 0, 0, 1, t);
        chk("ime_reti", {31'h0, ime}, 1);
        req(5'h01);
        chk("wake_vblank", {31'h0, wake}, 1);
        exp_vec.push_back(16'h0040);
        mcycle(1, 0, 0, 0, t);
        chk("take_vblank", {31'h0, t}, 1);
        chk("ime_cleared", {31'h0, ime}, 0);
        chk("active_wait0", {31'h0, disp_active}, 1);
        disp_tail(16'h0040, 8'hE0);

        // Priority: timer beats joypad
        wr(1, 8'h1F);
        req(5'h14);
        mcycle(0, 0, 0, 1, t);
        exp_vec.push_back(16'h0050);
        mcycle(1, 0, 0, 0, t);
        chk("take_timer", {31'h0, t}, 1);
        disp_tail(16'h0050, 8'hF0);

        // Cancel during PUSH_HI
        wr(0, 8'h00);
        req(5'h01);
        mcycle(0, 0, 0, 1, t);
        exp_vec.push_back(16'h0000);
        mcycle(1, 0, 0, 0, t);
        chk("take_cancel", {31'h0, t}, 1);
        mcycle(0, 0, 0, 0, t);
        mcycle(0, 0, 0, 0, t);
        chk("cancel_push_hi", {31'h0, disp_push_hi}, 1);
        wr(1, 8'h00);
        mcycle(0, 0, 0, 0, t);
        chk("cancel_vector", {16'h0, vector}, 0);
        rdreg(0, rd); chk("cancel_if", {24'h0, rd}, 32'hE1);
        mcycle(0, 0, 0, 0, t);
        mcycle(0, 0, 0, 0, t);
        chk("cancel_idle", {31'h0, disp_active}, 0);

        // EI delay
        wr(1, 8'h01);
        mcycle(1, 1, 0, 0, t);
        chk("ei_tick_no_take", {31'h0, t}, 0);
        mcycle(0, 0, 0, 0, t);
        mcycle(1, 0, 0, 0, t);
        chk("ei_first_boundary_no_take", {31'h0, t}, 0);
        chk("ei_ime_set", {31'h0, ime}, 1);
        exp_vec.push_back(16'h0040);
        mcycle(1, 0, 0, 0, t);
        chk("ei_second_boundary_take", {31'h0, t}, 1);
        disp_tail(16'h0040, 8'hE0);

        // EI and DI together: DI wins
        mcycle(0, 1, 1, 0, t);
        mcycle(1, 0, 0, 0, t);
        mcycle(1, 0, 0, 0, t);
        chk("ei_di_ime", {31'h0, ime}, 0);

        // HALT with ime=0: wake but no take
        halted = 1'b1;
        wr(1, 8'h04);
        req(5'h04);
        chk("halt_wake", {31'h0, wake}, 1);
        mcycle(1, 0, 0, 0, t);
        chk("halt_no_take", {31'h0, t}, 0);
        wr(0, 8'h00);
        chk("halt_wake_clr", {31'h0, wake}, 0);
        reg_wr_en = 1'b1; reg_sel = 1'b0; reg_wdata = 8'h00; irq_req = 5'h04;
        @(posedge clk); #1;
        reg_wr_en = 1'b0; irq_req = '0;
        rdreg(0, rd); chk("req_beats_write", {24'h0, rd}, 32'hE4);
        halted = 1'b0;

        // Reset during PUSH_LO
        wr(1, 8'h05);
        wr(0, 8'h05);
        mcycle(0, 0, 0, 1, t);
        mcycle(1, 0, 0, 0, t);
        chk("take_pre_rst", {31'h0, t}, 1);
        mcycle(0, 0, 0, 0, t);
        mcycle(0, 0, 0, 0, t);
        mcycle(0, 0, 0, 0, t);
        chk("pre_rst_push_lo", {31'h0, disp_push_lo}, 1);
        chk("pre_rst_vector", {16'h0, vector}, 32'h0040);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_active", {31'h0, disp_active}, 0);
        chk("mid_rst_push", {30'h0, disp_push_hi, disp_push_lo}, 0);
        chk("mid_rst_jump", {31'h0, disp_jump}, 0);
        chk("mid_rst_vector", {16'h0, vector}, 0);
        chk("mid_rst_ime", {31'h0, ime}, 0);
        rdreg(0, rd); chk("mid_rst_if", {24'h0, rd}, 32'hE0);
        rdreg(1, rd); chk("mid_rst_ie", {24'h0, rd}, 32'h00);

        chk("vec_queue_empty", exp_vec.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
